// File: rtl/amber128_pkg.sv
// Shared types and sizing for the amber128 capability datapath.
package amber128_pkg;

  localparam int CAP_REG_COUNT = 12;
  localparam int CAP_REG_AW    = 4;
  localparam int C_XLEN        = 128;

  localparam int CAPSF_CNT_W = CAP_REG_AW + 1;

  typedef enum logic [1:0] {
    CAPSF_IDLE,
    CAPSF_SPILL,
    CAPSF_FILL,
    CAPSF_DONE
  } capsf_state_e;

endpackage

// File: rtl/amber128_cap_spill_fill.sv
// Context-switch engine: streams a range of capability registers out (spill)
// or restores a range from an incoming stream (fill).
module amber128_cap_spill_fill
  import amber128_pkg::*;
#(
  parameter int N_REGS = CAP_REG_COUNT,
  parameter int AW     = CAP_REG_AW,
  parameter int XLEN   = C_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [AW-1:0]   first_i,
  input  logic [AW:0]     count_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [AW-1:0]   cf_raddr_o,
  input  logic [XLEN-1:0] cf_rdata_i,
  output logic            cf_we_o,
  output logic [AW-1:0]   cf_waddr_o,
  output logic [XLEN-1:0] cf_wdata_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic [XLEN-1:0] tx_data_o,
  output logic [AW-1:0]   tx_idx_o,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  input  logic [XLEN-1:0] rx_data_i
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_REGS_C = CW'(N_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

  capsf_state_e  state;
  logic [AW-1:0] idx;
  logic [CW-1:0] rem;
  logic [CW-1:0] start_cnt;
  logic          tx_hs;
  logic          tx_load;
  logic          rx_hs;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + AW'(1);
  endfunction

  assign start_cnt  = (count_i > N_REGS_C) ? N_REGS_C : count_i;
  assign busy_o     = (state != CAPSF_IDLE);
  assign done_o     = (state == CAPSF_DONE);
  assign rx_ready_o = (state == CAPSF_FILL) && (rem != '0);
  assign rx_hs      = rx_valid_i && rx_ready_o;
  assign tx_hs      = tx_valid_o && tx_ready_i;
  assign tx_load    = (!tx_valid_o || tx_ready_i) && (rem != '0);

  // The read port looks at first_i during the start cycle so the first beat
  // can be captured on the start edge itself.
  assign cf_raddr_o = (state == CAPSF_IDLE && start_i) ? first_i : idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CAPSF_IDLE;
      idx        <= '0;
      rem        <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      tx_idx_o   <= '0;
      cf_we_o    <= 1'b0;
      cf_waddr_o <= '0;
      cf_wdata_o <= '0;
    end else begin
      cf_we_o <= 1'b0;
      case (state)
        CAPSF_IDLE: begin
          if (start_i) begin
            if (start_cnt == '0) begin
              state <= CAPSF_DONE;
            end else if (!mode_i) begin
              tx_valid_o <= 1'b1;
              tx_data_o  <= cf_rdata_i;
              tx_idx_o   <= first_i;
              idx        <= next_idx(first_i);
              rem        <= start_cnt - CW'(1);
              state      <= CAPSF_SPILL;
            end else begin
              idx   <= first_i;
              rem   <= start_cnt;
              state <= CAPSF_FILL;
            end
          end
        end
        CAPSF_SPILL: begin
          if (abort_i) begin
            tx_valid_o <= 1'b0;
            state      <= CAPSF_IDLE;
          end else if (tx_load) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= cf_rdata_i;
            tx_idx_o   <= idx;
            idx        <= next_idx(idx);
            rem        <= rem - CW'(1);
          end else if (rem == '0 && (tx_hs || !tx_valid_o)) begin
            tx_valid_o <= 1'b0;
            state      <= CAPSF_DONE;
          end
        end
        CAPSF_FILL: begin
          // A handshake coinciding with abort still lands its write.
          if (rx_hs) begin
            cf_we_o    <= 1'b1;
            cf_waddr_o <= idx;
            cf_wdata_o <= rx_data_i;
            idx        <= next_idx(idx);
            rem        <= rem - CW'(1);
          end
          if (abort_i) begin
            state <= CAPSF_IDLE;
          end else if (rx_hs && rem == CW'(1)) begin
            state <= CAPSF_DONE;
          end
        end
        CAPSF_DONE: begin
          state <= CAPSF_IDLE;
        end
        default: begin
          state <= CAPSF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amber128_cap_spill_fill.sv
// Directed and randomized checks of the spill/fill engine against a
// queue-based model of the capability file and the two streams.
module tb_amber128_cap_spill_fill;
  import amber128_pkg::*;

  localparam int N    = CAP_REG_COUNT;
  localparam int AW   = CAP_REG_AW;
  localparam int XLEN = C_XLEN;
  typedef logic [XLEN-1:0] cap_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] first = '0;
  logic [AW:0]   count = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [AW-1:0] cf_raddr;
  cap_t          cf_rdata;
  logic          cf_we;
  logic [AW-1:0] cf_waddr;
  cap_t          cf_wdata;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  cap_t          tx_data;
  logic [AW-1:0] tx_idx;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  cap_t          rx_data = '0;

  cap_t mem [N];
  cap_t ref_mem [N];
  int   tests = 0;
  int   failed = 0;

  amber128_cap_spill_fill dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .first_i(first), .count_i(count), .abort_i(abort),
    .busy_o(busy), .done_o(done),
    .cf_raddr_o(cf_raddr), .cf_rdata_i(cf_rdata),
    .cf_we_o(cf_we), .cf_waddr_o(cf_waddr), .cf_wdata_o(cf_wdata),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_idx_o(tx_idx),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data)
  );

  always #5 clk = ~clk;

  function automatic cap_t preload(input int i);
    return cap_t'(i * 32'h1111);
  endfunction

  function automatic cap_t rand_cap();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural capability file: combinational read, one registered write port.
  assign cf_rdata = mem[cf_raddr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= preload(i);
    end else if (cf_we) begin
      mem[cf_waddr] <= cf_wdata;
    end
  end

  task automatic checkOutput(input string tag, input cap_t observed, input cap_t expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, cap_t'(observed), cap_t'(expected));
  endtask

  task automatic checkInt(input string tag, input int observed, input int expected);
    checkOutput(tag, cap_t'(observed), cap_t'(expected));
  endtask

  task automatic applyStimulus(input logic s, input logic m, input int f, input int c);
    start = s;
    mode  = m;
    first = AW'(f);
    count = (AW + 1)'(c);
  endtask

  task automatic checkResetState(input string pfx);
    checkBit({pfx, "_busy"}, busy, 1'b0);
    checkBit({pfx, "_done"}, done, 1'b0);
    checkBit({pfx, "_we"}, cf_we, 1'b0);
    checkBit({pfx, "_tx_valid"}, tx_valid, 1'b0);
    checkBit({pfx, "_rx_ready"}, rx_ready, 1'b0);
    checkOutput({pfx, "_tx_data"}, tx_data, '0);
    checkOutput({pfx, "_tx_idx"}, cap_t'(tx_idx), '0);
    checkOutput({pfx, "_waddr"}, cap_t'(cf_waddr), '0);
    checkOutput({pfx, "_wdata"}, cf_wdata, '0);
    checkOutput({pfx, "_raddr"}, cap_t'(cf_raddr), '0);
  endtask

  task automatic checkMemory(input string pfx);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s_mem%0d", pfx, i), mem[i], ref_mem[i]);
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic runSpill(input int f, input int c, input int rmode);
    int   n, cyc, last_hs, beats, any_we;
    bit   got_done, prev_stall, rdy;
    cap_t prev_data;
    logic [AW-1:0] prev_idx;
    int   exp_idx[$];
    cap_t exp_data[$];
    n = (c > N) ? N : c;
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back((f + k) % N);
      exp_data.push_back(ref_mem[(f + k) % N]);
    end
    applyStimulus(1'b1, 1'b0, f, c);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, f, c);
    checkBit("spill_busy", busy, 1'b1);
    checkBit("spill_first_valid", tx_valid, n > 0);
    cyc = 0; last_hs = -1; beats = 0; any_we = 0;
    got_done = 0; prev_stall = 0; prev_data = '0; prev_idx = '0;
    while (!got_done && cyc < 300) begin
      if (cf_we) any_we++;
      if (done) begin
        got_done = 1;
        checkInt("spill_done_latency", cyc, (n == 0) ? 0 : last_hs + 1);
        checkInt("spill_beats", beats, n);
        checkBit("spill_done_valid", tx_valid, 1'b0);
      end else begin
        start = (cyc == 1);
        mode  = 1'b1;
        if (prev_stall) begin
          checkBit("spill_stall_valid", tx_valid, 1'b1);
          checkOutput("spill_stall_data", tx_data, prev_data);
          checkOutput("spill_stall_idx", cap_t'(tx_idx), cap_t'(prev_idx));
        end
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        tx_ready = rdy;
        if (tx_valid && rdy) begin
          if (exp_idx.size() == 0) begin
            checkBit("spill_extra_beat", tx_valid, 1'b0);
          end else begin
            checkOutput("spill_idx", cap_t'(tx_idx), cap_t'(exp_idx.pop_front()));
            checkOutput("spill_data", tx_data, exp_data.pop_front());
          end
          if (rmode == 0) checkInt("spill_back_to_back", cyc, beats);
          beats++;
          last_hs = cyc;
        end
        prev_stall = tx_valid && !rdy;
        prev_data  = tx_data;
        prev_idx   = tx_idx;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    tx_ready = 1'b0;
    if (!got_done) checkBit("spill_timeout", done, 1'b1);
    checkInt("spill_no_write", any_we, 0);
    @(posedge clk); #1;
    checkBit("spill_idle_after_done", busy, 1'b0);
    checkBit("spill_done_one_cycle", done, 1'b0);
  endtask

  // abort_at < 0 disables abort; abort_hs makes the abort coincide with a handshake.
  task automatic runFill(input int f, input int c, input int abort_at, input bit abort_hs,
                         input bit fixed_data);
    int   n, cyc, hs;
    bit   finished, prev_hs, abort_prev, v;
    cap_t d;
    int   exp_idx[$];
    cap_t exp_data[$];
    n = (c > N) ? N : c;
    applyStimulus(1'b1, 1'b1, f, c);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, f, c);
    checkBit("fill_busy", busy, 1'b1);
    cyc = 0; hs = 0; finished = 0; prev_hs = 0; abort_prev = 0;
    while (!finished && cyc < 300) begin
      checkBit("fill_we", cf_we, prev_hs);
      if (cf_we && exp_idx.size() != 0) begin
        checkOutput("fill_waddr", cap_t'(cf_waddr), cap_t'(exp_idx.pop_front()));
        checkOutput("fill_wdata", cf_wdata, exp_data.pop_front());
      end
      if (abort_prev) begin
        finished = 1;
        abort = 1'b0;
        checkBit("abort_busy", busy, 1'b0);
        checkBit("abort_rx_ready", rx_ready, 1'b0);
        checkBit("abort_no_done", done, 1'b0);
      end else if (done) begin
        finished = 1;
        checkInt("fill_hs_count", hs, n);
        checkBit("fill_done_with_write", cf_we, n > 0);
        checkBit("fill_done_rx_ready", rx_ready, 1'b0);
      end else begin
        checkBit("fill_rx_ready", rx_ready, 1'b1);
        if (abort_at >= 0 && hs == abort_at) begin
          abort = 1'b1;
          abort_prev = 1;
          v = abort_hs;
        end else begin
          v = ($urandom_range(0, 3) != 0);
        end
        d = fixed_data ? cap_t'(10 + hs) : rand_cap();
        rx_valid = v;
        rx_data  = d;
        prev_hs  = v && rx_ready;
        if (prev_hs) begin
          exp_idx.push_back((f + hs) % N);
          exp_data.push_back(d);
          ref_mem[(f + hs) % N] = d;
          hs++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    rx_valid = 1'b0;
    abort = 1'b0;
    if (!finished) checkBit("fill_timeout", done, 1'b1);
    checkInt("fill_pending_writes", exp_idx.size(), 0);
    @(posedge clk); #1;
    checkBit("fill_idle_after", busy, 1'b0);
    checkBit("fill_we_after", cf_we, 1'b0);
    checkBit("fill_no_late_done", done, 1'b0);
    checkMemory("fill");
  endtask

  initial begin
    int f, c;
    for (int i = 0; i < N; i++) ref_mem[i] = preload(i);
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    checkBit("idle_after_reset", busy, 1'b0);

    runSpill(4, 3, 0);
    runSpill(4, 3, 1);
    runSpill(N - 2, 4, 2);
    runSpill(7, 0, 0);
    runSpill(3, N + 5, 2);

    runFill(N - 1, 2, -1, 1'b0, 1'b1);
    runFill(5, 0, -1, 1'b0, 1'b0);
    runFill(2, 4, 1, 1'b0, 1'b0);
    runFill(5, 3, -1, 1'b0, 1'b0);
    runFill(7, 4, 2, 1'b1, 1'b0);
    runSpill(0, N, 2);

    for (int it = 0; it < 6; it++) begin
      f = int'($urandom_range(0, N - 1));
      c = int'($urandom_range(0, N + 3));
      if ($urandom_range(0, 1) == 0) runSpill(f, c, 2);
      else runFill(f, c, -1, 1'b0, 1'b0);
    end

    // Reset in the middle of a stalled spill.
    tx_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 0, 8);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkBit("midrst_pre_valid", tx_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetState("midrst");
    rst = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = preload(i);
    @(posedge clk); #1;
    checkBit("midrst_stays_idle", busy, 1'b0);
    runSpill(10, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/amber128_cap_spill_fill.md
Name: amber128_cap_spill_fill

Overview:
Context-switch engine for the capability register file. In spill mode it drives one read port, walks a contiguous register range and streams each capability out over a valid/ready interface. In fill mode it accepts a valid/ready stream and drives the file's single write port, restoring the range. It sits between the capability file and the trap/context-switch memory path, and is only started while the core pipeline is stalled.

Parameters:
N_REGS, CAP_REG_COUNT, number of capability registers; indices wrap modulo N_REGS.
AW, CAP_REG_AW, register index width.
XLEN, C_XLEN, capability width.

Ports:
clk_i  in  1  clock; the only clock.
rst_i  in  1  reset, synchronous and active-high.
start_i  in  1  begin operation; sampled only in IDLE.
mode_i  in  1  0 = spill, 1 = fill; sampled with start_i.
first_i  in  AW  first register index; sampled with start_i.
count_i  in  AW+1  number of registers; sampled with start_i; values above N_REGS are clamped to N_REGS.
abort_i  in  1  cancel the current operation.
busy_o  out  1  high in SPILL/FILL/DONE.
done_o  out  1  one-cycle completion pulse.
cf_raddr_o  out  AW  capability file read address; combinational read.
cf_rdata_i  in  XLEN  capability file read data.
cf_we_o  out  1  capability file write enable.
cf_waddr_o  out  AW  capability file write address.
cf_wdata_o  out  XLEN  capability file write data.
tx_valid_o  out  1  spill stream valid.
tx_ready_i  in  1  spill stream ready.
tx_data_o  out  XLEN  spilled capability.
tx_idx_o  out  AW  register index of tx_data_o.
rx_valid_i  in  1  fill stream valid.
rx_ready_o  out  1  fill stream ready.
rx_data_i  in  XLEN  capability to restore.

Behaviour:
- Reset values: busy_o, done_o, cf_we_o, tx_valid_o and rx_ready_o = 0. Address, data and index outputs = 0. State = IDLE.
- Reset is synchronous: it is sampled only on a clk_i edge, and rst_i has priority over every other input, including during an active operation.
- States: IDLE, SPILL, FILL, DONE.
- Registers: idx (AW bits), rem (AW+1 bits).
- IDLE + start_i:
  - idx <= first_i; rem <= min(count_i, N_REGS).
  - Next state is SPILL (mode_i = 0) or FILL (mode_i = 1).
  - If the clamped count is 0, go directly to DONE.
- Spill:
  - cf_raddr_o = idx (combinational from state).
  - Output buffer (tx_data_o, tx_idx_o, tx_valid_o) is registered.
  - Load condition: (!tx_valid_o || tx_ready_i) && rem != 0. On load: tx_data_o <= cf_rdata_i, tx_idx_o <= idx, tx_valid_o <= 1, idx <= idx+1 mod N_REGS, rem <= rem-1.
  - This sustains one transfer per cycle when tx_ready_i is held high.
  - A handshake with no load clears tx_valid_o.
  - tx_data_o and tx_idx_o are held stable while tx_valid_o && !tx_ready_i.
  - Exit to DONE when rem == 0 and the last beat completes its handshake.
- Fill:
  - rx_ready_o = 1 while in FILL and rem != 0 (combinational).
  - On an rx handshake, the next cycle registers cf_we_o = 1, cf_waddr_o = idx, cf_wdata_o = rx_data_i. Same edge: idx increments (wrapping), rem decrements.
  - cf_we_o is low in every cycle not following a handshake.
  - Exit to DONE when the final handshake occurs; the final write is issued in the same cycle the state is DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Latencies:
  - Spill: first tx_valid_o 1 cycle after start.
  - Fill: each write 1 cycle after its handshake.
  - Both modes: done_o 1 cycle after the last tx handshake, or in the cycle of the last cf_we_o.
- Wrap-around: first_i = N_REGS-2 with count 4 visits N_REGS-2, N_REGS-1, 0, 1.
- start_i outside IDLE is ignored.
- abort_i in SPILL or FILL:
  - Next cycle goes to IDLE with tx_valid_o = 0 and rx_ready_o = 0; no done_o.
  - A write already registered from the previous handshake still completes.
  - In IDLE or DONE, abort_i is ignored.
- Simultaneous abort_i and handshake: the handshake counts, then the engine aborts.

Decomposition:
- amber128_pkg gains:
  - capsf_state_e enum (IDLE, SPILL, FILL, DONE).
  - CAPSF_CNT_W = CAP_REG_AW+1.
- Existing CAP_REG_AW, CAP_REG_COUNT and C_XLEN are reused.
- No sub-module; the FSM and datapath stay in one module.
- The top level connects cf_raddr_o/cf_rdata_i to capfile read port 2 and muxes cf_we_o/cf_waddr_o/cf_wdata_o into the capfile write port while busy_o is high.

Test Plan:
- Spill, first=4, count=3, tx_ready_i held 1, file preloaded with caps[i]=i*0x1111: tx beats idx 4,5,6 on consecutive cycles starting 1 cycle after start; done_o 1 cycle after the idx 6 handshake.
- Spill with tx_ready_i toggling 1,0,0,1: tx_data_o and tx_idx_o are stable while stalled; no beat is dropped or duplicated; exactly 3 beats.
- Fill, first=N_REGS-1, count=2, rx values 0xA, 0xB: cf_we_o writes index N_REGS-1=0xA then index 0=0xB; done_o coincides with the second write; other registers unchanged.
- count_i=0 -> done_o 1 cycle after start, with no tx beat and no cf_we_o.
- count_i=N_REGS+5 -> exactly N_REGS beats.
- abort_i during fill after 1 of 4 handshakes -> exactly one write, no done_o, idle next cycle, and a new start is accepted.
- rst_i asserted mid-spill with tx_valid_o=1 -> all outputs 0 at the next edge and state IDLE.
